// File: rtl/regfile_port_seq.sv
// Register-file port sequencer.
// Walks a contiguous, wrapping range of register indices and either streams
// their contents out (dump) or writes an incoming word stream into them (load).
// Writes aimed at x0 are consumed from the stream but never reach the regfile.
//
// Ports:
//   clk, reset (async, active-low), abort (sync, ignored in IDLE)
//   cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_count : command handshake
//   out_valid/out_ready/out_data/out_addr         : dump stream, one-entry stage
//   in_valid/in_ready/in_data                     : load stream
//   rf_raddr/rf_rd                                : regfile read port (comb read)
//   rf_waddr/rf_we/rf_wd                          : regfile write port
//   busy, done (1-cycle pulse), err (1-cycle pulse on rejected command)
module regfile_port_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NREGS);

  typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;

  logic cmd_accept;
  logic cmd_bad;
  logic slot_free;
  logic load_hs;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // A command coinciding with abort is not taken, even though abort is
  // otherwise a no-op in IDLE.
  assign cmd_accept = cmd_valid & cmd_ready & ~abort;
  assign cmd_bad    = (cmd_count == '0) || (cmd_count > NREGS_C);

  assign in_ready = (state == LOAD) && (remaining != '0);
  assign load_hs  = in_valid & in_ready;

  assign rf_raddr = ptr;
  assign rf_waddr = ptr;
  assign rf_wd    = in_data;
  assign rf_we    = load_hs && (ptr != '0);

  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if ((state != IDLE) && abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_accept) begin
              if (cmd_bad) begin
                err <= 1'b1;
              end else begin
                ptr       <= cmd_base;
                remaining <= cmd_count;
                state     <= cmd_op ? LOAD : DUMP;
              end
            end
          end
          DUMP: begin
            if (slot_free) begin
              if (remaining != '0) begin
                out_data  <= rf_rd;
                out_addr  <= ptr;
                out_valid <= 1'b1;
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W + 1)'(1);
              end else begin
                out_valid <= 1'b0;
                state     <= DONE;
                done      <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (remaining == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (load_hs) begin
              ptr       <= ptr + ADDR_W'(1);
              remaining <= remaining - (ADDR_W + 1)'(1);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/regfile_port_seq.md
Name: regfile_port_seq

Overview:
- Bus-side initiator for the 32x32 register file's read/write ports: walks a contiguous register range and either streams contents out (dump) or writes an incoming stream into it (load).
- Sits between the debug/test host and the regfile:
  - rf_raddr and rf_rd connect to A1 and RD1.
  - rf_waddr, rf_we and rf_wd connect to A3, WE3 and WD3.
- Used for bring-up preload, architectural-state dump and register scrubbing.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous abort; returns the block to IDLE.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  1  0 = dump, 1 = load.
- cmd_base  in  ADDR_W  first register index.
- cmd_count  in  ADDR_W+1  number of registers, legal range 1..NREGS.
- out_valid  out  1  dump word available.
- out_ready  in  1  sink accepts the dump word.
- out_data  out  DATA_W  dumped register value.
- out_addr  out  ADDR_W  index of out_data.
- in_valid  in  1  load word offered.
- in_ready  out  1  block accepts a load word.
- in_data  in  DATA_W  load word.
- rf_raddr  out  ADDR_W  regfile read address.
- rf_rd  in  DATA_W  regfile read data (combinational read).
- rf_waddr  out  ADDR_W  regfile write address.
- rf_we  out  1  regfile write enable.
- rf_wd  out  DATA_W  regfile write data.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; ptr, remaining, out_valid, out_data, out_addr, done and err all go to 0.
  - Combinational outputs: cmd_ready=1, in_ready=0, rf_we=0, busy=0.
- States: IDLE, DUMP, LOAD, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on cmd_valid & cmd_ready.
  - If cmd_count is 0 or greater than NREGS: err pulses for 1 cycle, the command is dropped and the state stays IDLE.
  - Otherwise: ptr <= cmd_base, remaining <= cmd_count, and the next state is DUMP (op=0) or LOAD (op=1).
- ptr arithmetic is modulo NREGS, so 31 increments to 0.
- rf_raddr = ptr at all times; rf_waddr = ptr; rf_wd = in_data.
- DUMP (registered output stage, one entry):
  - A slot is free when !out_valid or (out_valid & out_ready).
  - If the slot is free and remaining > 0: out_data <= rf_rd, out_addr <= ptr, out_valid <= 1, ptr++, remaining--.
  - If the slot is free and remaining == 0: out_valid <= 0, next state is DONE.
  - Latency: command accepted in cycle N gives the first out_valid in cycle N+2. With out_ready held high, one word per cycle follows.
  - While out_valid & !out_ready, out_data and out_addr are held stable: no drop, no duplicate.
- LOAD:
  - in_ready = (remaining > 0).
  - rf_we = in_valid & in_ready & (ptr != 0), combinational.
  - On handshake: ptr++, remaining--. A word targeting x0 is consumed but not written.
  - When remaining == 0, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 throughout DUMP, LOAD and DONE.
- abort high in any non-IDLE state: next state is IDLE, out_valid <= 0, no done pulse. abort is ignored in IDLE.
- A command offered in the same cycle as abort is not accepted.
- Reset asserted mid-operation: immediate IDLE with reset values. Writes already issued remain in the regfile.

Test Plan:
1. Load: op=1, base=1, count=3, in data 0x1, 0x2, 0x12 with in_valid held -> rf_we high for 3 cycles at addresses 1, 2, 3; regfile x1=0x1, x2=0x2, x3=0x12; done pulses once, then busy=0.
2. Dump: after test 1, op=0, base=0, count=4, out_ready=1 -> (addr, data) = (0, 0x0), (1, 0x1), (2, 0x2), (3, 0x12) in consecutive cycles starting at N+2; then done.
3. Backpressure: same dump with out_ready toggled 1,0,0,1,0,1… -> out_data and out_addr stable while stalled; exactly 4 words, in order.
4. Wrap and x0: load base=31, count=3, data 0xA, 0xB, 0xC -> x31=0xA, x0 write suppressed (rf_we=0, x0 reads 0), x1=0xC; then dump base=30, count=4 -> addresses 30, 31, 0, 1.
5. Errors: count=0 and count=33 -> err pulses 1 cycle each, busy stays 0, no rf_we and no out_valid.
6. Abort and reset: abort during dump after 2 words -> out_valid=0 next cycle, no done, cmd_ready=1. Reset low mid-load -> in_ready and rf_we drop to 0 immediately, and a fresh command works after reset.
